// File: rtl/divider_pkg.sv
// Shared types for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // The trial value is one bit wider than the divisor, so the compare and subtract never overflow.
  always_comb begin
    trial   = {rem_i, bit_i};
    diff    = trial - {1'b0, divisor_i};
    q_bit_o = (trial >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff : trial;
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, start/busy/valid handshake.
// Optional macro DIVIDER_DIV_ZERO_DETECT_EN short-cuts zero divisors straight to DONE.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic             unused_rem_msb;

  // The remainder MSB only exists to keep the step arithmetic wide; it is always zero after a step.
  assign unused_rem_msb = rem_q[WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q[WIDTH-1:0]),
    .bit_i     (q_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
  assign div_by_zero_o = dbz_q;
`else
  assign div_by_zero_o = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    dbz_d     = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = CALC;
          divisor_d = divisor_i;
          q_d       = dividend_i;
          rem_d     = '0;
          cnt_d     = '0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
          dbz_d     = 1'b0;
          if (divisor_i == '0) begin
            state_d = DONE;
            q_d     = '1;
            rem_d   = {1'b0, dividend_i};
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        q_d   = {q_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign busy_o      = (state_q == CALC);
  assign valid_o     = (state_q == DONE);
  assign quotient_o  = q_q;
  assign remainder_o = rem_q[WIDTH-1:0];

endmodule

// File: doc/divider.md
# divider

Sequential restoring divider, the inverse operation of the team's shift-add multiplier, with the same start/busy/valid handshake. Captures an unsigned dividend and divisor on `start_i` and produces one quotient bit per cycle, MSB first. Results are held with `valid_o` high until the next start. Intended as a drop-in arithmetic unit next to the multiplier in the same datapath.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits; legal range 2..32.
- `clk_i`  input  1  single clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `start_i`  input  1  start request; sampled only in IDLE or DONE.
- `dividend_i`  input  WIDTH  unsigned dividend; captured when start is accepted.
- `divisor_i`  input  WIDTH  unsigned divisor; captured when start is accepted.
- `busy_o`  output  1  high while in CALC.
- `valid_o`  output  1  high while in DONE; results are stable.
- `quotient_o`  output  WIDTH  quotient; meaningful only while `valid_o` is high.
- `remainder_o`  output  WIDTH  remainder; meaningful only while `valid_o` is high.
- `div_by_zero_o`  output  1  divisor was zero; meaningful with `valid_o` (see Configuration).

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on `start_i`. DONE → CALC on `start_i`. DONE with no start stays in DONE and holds outputs. CALC ignores `start_i`.
- Start accepted:
  - Latch the divisor.
  - Load the quotient register with the dividend, which is shifted out MSB-first.
  - Clear the partial remainder (WIDTH+1 bits).
  - Clear the step counter ($clog2(WIDTH) bits).
  - Clear `div_by_zero_o`.
- Each CALC cycle:
  - Form `r = {rem[WIDTH-1:0], q[WIDTH-1]}`.
  - Shift `q` left.
  - If `r >= {1'b0, divisor}`: `rem = r - divisor` and `q[0] = 1`. Otherwise `rem = r` and `q[0] = 0`.
  - Increment the counter.
- CALC → DONE after the step with counter == WIDTH-1. Exactly WIDTH CALC cycles.
- `remainder_o` = `rem[WIDTH-1:0]`. `quotient_o` = `q`. Both are driven directly from the registers.
- Arithmetic is unsigned only. The compare/subtract is WIDTH+1 bits wide, so there is no overflow.
- Divisor zero (macro disabled): the algorithm runs normally and yields quotient = all ones, remainder = dividend.
- Reset values, applied at the next edge with `rst_i` high:
  - state = IDLE;
  - all registers = 0;
  - `busy_o` = `valid_o` = `div_by_zero_o` = 0;
  - `quotient_o` = `remainder_o` = 0.
- Reset mid-CALC aborts the operation. No result is produced.
- Reset has priority over a simultaneous `start_i`.

## Timing
- `start_i` sampled high at edge E0 in IDLE/DONE:
  - `busy_o` is high for cycles after E0 through E(WIDTH-1).
  - At E(WIDTH), state = DONE and `valid_o` goes high.
  - Latency: WIDTH+1 edges from the accepting edge to `valid_o`.
- `valid_o` and `busy_o` are never high together.
- Back-to-back: `start_i` held high in DONE re-enters CALC at the next edge. `valid_o` drops for WIDTH cycles.
- Operand inputs may change freely after the accepting edge.

## Configuration
- `DIVIDER_DIV_ZERO_DETECT_EN` defined:
  - On start with `divisor_i == 0`, go directly to DONE at the next edge (0 CALC cycles).
  - Set quotient = all ones and remainder = dividend.
  - `div_by_zero_o` = 1 while in DONE.
- Not defined: `div_by_zero_o` is tied to 0 and zero divisors take the full WIDTH cycles. The result values are identical in both builds.

## Structure
- `divider_pkg`: state enum typedef (`div_state_t`: IDLE, CALC, DONE).
- Sub-module `div_step`: purely combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Parameterized by `WIDTH`.
- Top level contains the FSM, counter and registers, and instantiates one `div_step`.

## Test plan
- WIDTH=8, start with 200 / 7 → `busy_o` for 8 cycles, then `valid_o`=1, quotient 28, remainder 4; outputs held 5 further cycles with no start.
- 5 / 9 → quotient 0, remainder 5. Then 255 / 1 → quotient 255, remainder 0. Then 255 / 255 → quotient 1, remainder 0.
- 77 / 0, both builds → quotient 255, remainder 77:
  - with macro: `valid_o` one edge after start and `div_by_zero_o`=1;
  - without macro: `valid_o` after 9 edges and `div_by_zero_o`=0.
- Pulse `start_i` with new operands on cycle 3 of CALC → ignored. The original result is returned with unchanged latency.
- Assert `rst_i` on cycle 4 of CALC together with `start_i` → next edge gives IDLE and all outputs 0. A following start of 100 / 10 → quotient 10, remainder 0.
- `start_i` held high continuously across two operations, 200 / 7 then 9 / 2 (operands changed in DONE) → 28r4, then `valid_o` low for 8 cycles, then 4r1.
